// File: rtl/td_mac_array.sv
// td_mac_array: multi-channel time-domain multiply-accumulate.
// Each channel input x_i becomes a pulse x_i cycles long. While a channel's
// pulse is high, its coefficient w_i is added into one shared accumulator
// every cycle, so one frame yields sum(w_i * x_i). The result can build up
// across frames. When it does, it saturates at the top of the ACC_W range
// and sets a sticky overflow flag.
//
// Handshakes (valid/ready):
//   - Input side: a frame is accepted on a rising edge where in_valid and
//     in_ready are both 1. in_ready is 1 only in IDLE.
//   - Output side: out_valid stays 1 and out stays stable until a rising edge
//     where out_ready is 1. After that edge the block returns to IDLE.
//   - in/coeff/acc_en are sampled only on the accept edge.
module td_mac_array #(
   parameter int unsigned N_BIT      = 2,
   parameter int unsigned W_BIT      = 2,
   parameter int unsigned N_CH       = 4,
   parameter bit          EARLY_EXIT = 1'b0,
   localparam int unsigned CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1,
   localparam int unsigned ACC_W     = N_BIT + W_BIT + CH_W
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [N_CH*N_BIT-1:0]   in,
   input  logic [N_CH*W_BIT-1:0]   coeff,
   input  logic                    acc_en,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [ACC_W-1:0]        out,
   output logic                    ovf,
   output logic                    t,
   output logic                    busy,
   output logic [1:0]              fsm_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ENC  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int unsigned MAXX = (2 ** N_BIT) - 1;
   localparam logic [N_BIT-1:0] LAST_TCNT = N_BIT'(MAXX - 1);

   state_t state;
   state_t state_nxt;

   logic [N_BIT-1:0] x_r [N_CH];
   logic [W_BIT-1:0] w_r [N_CH];
   logic [N_BIT-1:0] tcnt;
   logic [ACC_W-1:0] acc;
   logic             ovf_r;

   logic [N_CH-1:0]  pulse;
   logic [ACC_W-1:0] step;
   logic [N_BIT-1:0] max_x;
   logic [ACC_W:0]   sum_wide;
   logic             last_cycle;
   logic             accept;

   // Channel pulses, this cycle's coefficient sum, and the longest pulse.
   always_comb begin
      pulse = '0;
      step  = '0;
      max_x = '0;
      for (int i = 0; i < int'(N_CH); i++) begin
         pulse[i] = (tcnt < x_r[i]);
         if (pulse[i]) begin
            step = step + ACC_W'(w_r[i]);
         end
         if (x_r[i] > max_x) begin
            max_x = x_r[i];
         end
      end
   end

   // Accumulator plus one carry bit, so saturation can be detected.
   assign sum_wide = {1'b0, acc} + {1'b0, step};

   // Last encode cycle: either the full window or the end of the longest pulse.
   // When every x_i is 0 the early-exit form still spends one cycle in ENC.
   assign last_cycle = EARLY_EXIT ? (({1'b0, tcnt} + (N_BIT + 1)'(1)) >= {1'b0, max_x})
                                  : (tcnt == LAST_TCNT);

   assign accept = in_valid && (state == IDLE);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic: IDLE -> ENC -> DONE -> IDLE.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (in_valid) state_nxt = ENC;
         ENC:  if (last_cycle) state_nxt = DONE;
         DONE: if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: capture on accept, then accumulate and count during ENC.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(N_CH); i++) begin
            x_r[i] <= '0;
            w_r[i] <= '0;
         end
         tcnt  <= '0;
         acc   <= '0;
         ovf_r <= 1'b0;
      end else if (accept) begin
         for (int i = 0; i < int'(N_CH); i++) begin
            x_r[i] <= in[i*N_BIT +: N_BIT];
            w_r[i] <= coeff[i*W_BIT +: W_BIT];
         end
         tcnt <= '0;
         if (!acc_en) begin
            acc   <= '0;
            ovf_r <= 1'b0;
         end
      end else if (state == ENC) begin
         tcnt <= tcnt + N_BIT'(1);
         if (sum_wide[ACC_W]) begin
            acc   <= '1;
            ovf_r <= 1'b1;
         end else begin
            acc <= sum_wide[ACC_W-1:0];
         end
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);
   assign t         = (state == ENC) && (|pulse);
   assign out       = acc;
   assign ovf       = ovf_r;
   assign fsm_state = state;

endmodule

// File: tb/tb_td_mac_array.sv
// Bench for td_mac_array. It runs three instances:
//   - dut 0: default configuration
//   - dut 1: early exit enabled
//   - dut 2: single channel, 3-bit input and coefficient
// An arithmetic model (sum of w*x with saturation) pushes the expected
// results into a queue when each frame is driven. They are popped and
// compared when out_valid appears.
module tb_td_mac_array;

   logic clk = 1'b0;
   logic rst;

   logic       iv   [3];
   logic       ordy [3];
   logic       ae   [3];
   logic [7:0] in_s [3];
   logic [7:0] co_s [3];

   logic       ir     [3];
   logic       ov     [3];
   logic       ovf_s  [3];
   logic       t_s    [3];
   logic       busy_s [3];
   logic [1:0] st_s   [3];
   logic [7:0] out_s  [3];
   logic [5:0] out0;
   logic [5:0] out1;
   logic [6:0] out2;

   // Per-instance configuration, as seen by the model.
   int nb [3] = '{2, 2, 3};
   int wb [3] = '{2, 2, 3};
   int nc [3] = '{4, 4, 1};
   int ee [3] = '{0, 1, 0};
   int aw [3] = '{6, 6, 7};

   int   m_acc [3];
   logic m_ovf [3];

   logic [7:0] exp_q[$];
   logic       exp_ovf_q[$];
   int         exp_lat_q[$];

   int n_checks = 0;
   int n_fail   = 0;
   int tc;

   // Clock.
   always #5 clk = ~clk;

   always_comb begin
      out_s[0] = {2'b00, out0};
      out_s[1] = {2'b00, out1};
      out_s[2] = {1'b0, out2};
   end

   td_mac_array #(.N_BIT(2), .W_BIT(2), .N_CH(4), .EARLY_EXIT(1'b0)) dut0 (
      .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in(in_s[0]),
      .coeff(co_s[0]), .acc_en(ae[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
      .out(out0), .ovf(ovf_s[0]), .t(t_s[0]), .busy(busy_s[0]), .fsm_state(st_s[0])
   );

   td_mac_array #(.N_BIT(2), .W_BIT(2), .N_CH(4), .EARLY_EXIT(1'b1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in(in_s[1]),
      .coeff(co_s[1]), .acc_en(ae[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
      .out(out1), .ovf(ovf_s[1]), .t(t_s[1]), .busy(busy_s[1]), .fsm_state(st_s[1])
   );

   td_mac_array #(.N_BIT(3), .W_BIT(3), .N_CH(1), .EARLY_EXIT(1'b0)) dut2 (
      .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in(in_s[2][2:0]),
      .coeff(co_s[2][2:0]), .acc_en(ae[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
      .out(out2), .ovf(ovf_s[2]), .t(t_s[2]), .busy(busy_s[2]), .fsm_state(st_s[2])
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] p4(input logic [1:0] a, input logic [1:0] b,
                                     input logic [1:0] c, input logic [1:0] d);
      return {d, c, b, a};
   endfunction

   task automatic clear_model();
      for (int i = 0; i < 3; i++) begin
         m_acc[i] = 0;
         m_ovf[i] = 1'b0;
      end
   endtask

   // Drive one frame, push its expected result, then collect and compare it.
   // hold > 0 keeps out_ready low for that many cycles of out_valid.
   task automatic send(input int sel, input logic [7:0] x, input logic [7:0] w,
                       input logic acc_en, input int hold, output int tcount);
      int sum, mx, lat, xi, wi, mask, wmask, amax;
      logic [7:0] e;
      logic       eo;
      mask  = (1 << nb[sel]) - 1;
      wmask = (1 << wb[sel]) - 1;
      amax  = (1 << aw[sel]) - 1;
      sum   = 0;
      mx    = 0;
      for (int i = 0; i < nc[sel]; i++) begin
         xi  = int'(x >> (i * nb[sel])) & mask;
         wi  = int'(w >> (i * wb[sel])) & wmask;
         sum += xi * wi;
         if (xi > mx) mx = xi;
      end
      if (!acc_en) begin
         m_acc[sel] = 0;
         m_ovf[sel] = 1'b0;
      end
      m_acc[sel] += sum;
      if (m_acc[sel] > amax) begin
         m_acc[sel] = amax;
         m_ovf[sel] = 1'b1;
      end
      exp_q.push_back(8'(m_acc[sel]));
      exp_ovf_q.push_back(m_ovf[sel]);
      exp_lat_q.push_back((ee[sel] != 0) ? (((mx < 1) ? 1 : mx) + 1) : (mask + 1));

      tcount = 0;
      @(negedge clk);
      check("in_ready_idle", 32'(ir[sel]), 32'd1);
      iv[sel]   = 1'b1;
      in_s[sel] = x;
      co_s[sel] = w;
      ae[sel]   = acc_en;
      ordy[sel] = (hold == 0);
      @(negedge clk);
      iv[sel]   = 1'b0;
      in_s[sel] = 8'($urandom);
      co_s[sel] = 8'($urandom);
      ae[sel]   = 1'($urandom);
      lat = 1;
      while (!ov[sel] && lat < 200) begin
         if (t_s[sel]) tcount++;
         @(negedge clk);
         lat++;
      end
      e  = exp_q.pop_front();
      eo = exp_ovf_q.pop_front();
      if (!ov[sel]) begin
         check("out_valid_timeout", 32'(ov[sel]), 32'd1);
         void'(exp_lat_q.pop_front());
         ordy[sel] = 1'b1;
         return;
      end
      check("latency", 32'(lat), 32'(exp_lat_q.pop_front()));
      check("out", 32'(out_s[sel]), 32'(e));
      check("ovf", 32'(ovf_s[sel]), 32'(eo));
      for (int i = 0; i < hold; i++) begin
         check("hold_valid", 32'(ov[sel]), 32'd1);
         check("hold_out", 32'(out_s[sel]), 32'(e));
         check("hold_in_ready", 32'(ir[sel]), 32'd0);
         iv[sel]   = ((i % 2) == 0) && (i < hold - 1);
         in_s[sel] = 8'($urandom);
         co_s[sel] = 8'($urandom);
         if (i == hold - 1) ordy[sel] = 1'b1;
         @(negedge clk);
      end
      if (hold == 0) @(negedge clk);
      check("in_ready_after", 32'(ir[sel]), 32'd1);
      check("valid_after", 32'(ov[sel]), 32'd0);
   endtask

   task automatic check_idle_zero(input int sel);
      check("rst_out", 32'(out_s[sel]), 32'd0);
      check("rst_valid", 32'(ov[sel]), 32'd0);
      check("rst_ovf", 32'(ovf_s[sel]), 32'd0);
      check("rst_t", 32'(t_s[sel]), 32'd0);
      check("rst_busy", 32'(busy_s[sel]), 32'd0);
      check("rst_in_ready", 32'(ir[sel]), 32'd1);
      check("rst_state", 32'(st_s[sel]), 32'd0);
   endtask

   initial begin
      logic [7:0] rx, rw;
      logic       ra;
      int         bits;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         iv[i]   = 1'b0;
         ordy[i] = 1'b1;
         ae[i]   = 1'b0;
         in_s[i] = '0;
         co_s[i] = '0;
      end
      clear_model();

      // Reset state.
      repeat (3) @(negedge clk);
      for (int s = 0; s < 3; s++) check_idle_zero(s);
      rst = 1'b0;
      @(negedge clk);

      // Full-window frame: 3+4+3+0 = 10, t high for 3 cycles.
      send(0, p4(3, 2, 1, 0), p4(1, 2, 3, 3), 1'b0, 0, tc);
      check("t_cycles", 32'(tc), 32'd3);

      // Accumulation chain with saturation and sticky ovf.
      send(0, p4(3, 3, 3, 3), p4(3, 3, 3, 3), 1'b0, 0, tc);
      send(0, p4(3, 3, 3, 3), p4(3, 3, 3, 3), 1'b1, 0, tc);
      send(0, p4(3, 3, 3, 3), p4(3, 3, 3, 3), 1'b0, 0, tc);

      // Back-pressure: out_ready low for 5 cycles, in_valid pulses ignored.
      send(0, p4(1, 2, 3, 0), p4(3, 1, 2, 1), 1'b1, 5, tc);

      // Reset during the second ENC cycle aborts the frame.
      @(negedge clk);
      iv[0]   = 1'b1;
      in_s[0] = p4(3, 3, 3, 3);
      co_s[0] = p4(3, 3, 3, 3);
      ae[0]   = 1'b1;
      @(negedge clk);
      iv[0] = 1'b0;
      check("enc_busy", 32'(busy_s[0]), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      for (int s = 0; s < 3; s++) check_idle_zero(s);
      clear_model();
      @(negedge clk);
      rst = 1'b0;
      send(0, p4(2, 0, 0, 0), p4(3, 0, 0, 0), 1'b1, 0, tc);

      // Early exit: short pulses, all-zero inputs, zero-weight pulse length.
      send(1, p4(1, 1, 0, 0), p4(3, 3, 3, 3), 1'b0, 0, tc);
      send(1, p4(0, 0, 0, 0), p4(3, 3, 3, 3), 1'b0, 0, tc);
      send(1, p4(0, 3, 0, 0), p4(0, 0, 0, 0), 1'b0, 0, tc);
      check("t_zero_weight", 32'(tc), 32'd3);

      // Single-channel wide instance: 7*5 = 35 after 8 cycles.
      send(2, 8'd7, 8'd5, 1'b0, 0, tc);

      // Randomised frames on every instance.
      for (int s = 0; s < 3; s++) begin
         bits = nb[s] * nc[s];
         for (int k = 0; k < 20; k++) begin
            rx = 8'($urandom & ((1 << bits) - 1));
            rw = 8'($urandom & ((1 << (wb[s] * nc[s])) - 1));
            ra = ($urandom_range(0, 2) != 0);
            send(s, rx, rw, ra, (k == 7) ? 2 : 0, tc);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
